fetch_unit: RTL and testbench

- Program-counter and fetch-control stage directly upstream of the synchronous instruction ROM in the MIPS processor.
- Generates the ROM read address and ROM stall strobe.
- Applies branch/jump redirects from decode, honouring the MIPS delay slot.
- Tracks the PC and validity of the word currently on the ROM output for downstream decode.
- Detects illegal redirect targets and halts fetch on a fault or halt request.

---
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: program counter and fetch control for the MIPS instruction ROM.
// Drives the ROM read address and stall strobe, applies decode redirects
// (with optional delay slot), tracks PC/validity of the word on the ROM
// output, and stops fetching on an illegal redirect target or halt request.
//
// Ports:
//   clock, reset      clock; synchronous active-high reset
//   stall             downstream stall (hold PC and ROM output word)
//   redirect          taken branch/jump this cycle
//   redirect_target   byte address of the redirect
//   halt_req          stop fetching (break/syscall)
//   rom_addr          ROM read address (PC register)
//   rom_stall         ROM stall strobe (only combinational output)
//   inst_pc           byte PC of the word on ROM data_out
//   inst_valid        ROM data_out holds a real, non-squashed instruction
//   fault, fault_addr sticky illegal-redirect flag and offending target
//   fetch_count       valid instructions delivered (wraps)
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  output logic [31:0] rom_addr,
  output logic        rom_stall,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_RUN,
    S_HALTED,
    S_FAULT
  } state_e;

  // Byte-address bits above the ROM range must all be zero.
  localparam int unsigned TOP_BIT = ADDR_WIDTH + 2;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        target_legal;

  assign target_legal = (redirect_target[1:0] == 2'b00) &&
                        ((redirect_target >> TOP_BIT) == 32'd0);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_pc_d     = inst_pc_q;
    inst_valid_d  = inst_valid_q;
    fault_d       = fault_q;
    fault_addr_d  = fault_addr_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      S_RUN: begin
        if (redirect) begin
          if (!target_legal) begin
            state_d      = S_FAULT;
            fault_d      = 1'b1;
            fault_addr_d = redirect_target;
            inst_valid_d = 1'b0;
          end else begin
            // Stall is overridden: the ROM reads the delay-slot word at pc_q.
            pc_d      = redirect_target;
            inst_pc_d = pc_q;
            if (halt_req) begin
              state_d      = S_HALTED;
              inst_valid_d = 1'b0;
            end else begin
              inst_valid_d = DELAY_SLOT;
              if (DELAY_SLOT) fetch_count_d = fetch_count_q + 32'd1;
            end
          end
        end else if (halt_req) begin
          state_d      = S_HALTED;
          inst_valid_d = 1'b0;
        end else if (!stall) begin
          pc_d          = pc_q + 32'd4;
          inst_pc_d     = pc_q;
          inst_valid_d  = 1'b1;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      default: begin
        inst_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_RUN;
      pc_q          <= RESET_PC;
      inst_pc_q     <= '0;
      inst_valid_q  <= 1'b0;
      fault_q       <= 1'b0;
      fault_addr_q  <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_pc_q     <= inst_pc_d;
      inst_valid_q  <= inst_valid_d;
      fault_q       <= fault_d;
      fault_addr_q  <= fault_addr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign rom_stall   = (state_q == S_RUN) ? (stall & ~redirect) : 1'b1;
  assign rom_addr    = pc_q;
  assign inst_pc     = inst_pc_q;
  assign inst_valid  = inst_valid_q;
  assign fault       = fault_q;
  assign fault_addr  = fault_addr_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: two instances (delay slot off / on) share the
// stimulus and are compared every cycle against a behavioural model, with
// extra hand-computed literal checks along the directed sequence.
module tb_fetch_unit;

  localparam longint ROM_LIMIT = 4 * (64'd1 << 8);

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        halt_req = 1'b0;

  logic [31:0] rom_addr_w    [2];
  logic        rom_stall_w   [2];
  logic [31:0] inst_pc_w     [2];
  logic        inst_valid_w  [2];
  logic        fault_w       [2];
  logic [31:0] fault_addr_w  [2];
  logic [31:0] fetch_count_w [2];

  int nvec  = 0;
  int nfail = 0;

  always #5 clock = ~clock;

  // Index 0: delay slot squashed, index 1: delay slot kept.
  fetch_unit #(.RESET_PC(32'h0), .ADDR_WIDTH(8), .DELAY_SLOT(1'b0)) dut0 (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .halt_req(halt_req),
    .rom_addr(rom_addr_w[0]), .rom_stall(rom_stall_w[0]),
    .inst_pc(inst_pc_w[0]), .inst_valid(inst_valid_w[0]),
    .fault(fault_w[0]), .fault_addr(fault_addr_w[0]),
    .fetch_count(fetch_count_w[0])
  );

  fetch_unit #(.RESET_PC(32'h0), .ADDR_WIDTH(8), .DELAY_SLOT(1'b1)) dut1 (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .halt_req(halt_req),
    .rom_addr(rom_addr_w[1]), .rom_stall(rom_stall_w[1]),
    .inst_pc(inst_pc_w[1]), .inst_valid(inst_valid_w[1]),
    .fault(fault_w[1]), .fault_addr(fault_addr_w[1]),
    .fetch_count(fetch_count_w[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = fetching, 1 = halted, 2 = faulted.
  logic [31:0] m_pc [2], m_ipc [2], m_fa [2], m_cnt [2];
  logic        m_iv [2], m_fl [2];
  int          m_mode [2];
  bit          m_init = 1'b0;

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      logic [31:0] pc, ipc, fa, cnt;
      logic        iv, fl;
      int          md;
      bit          legal;
      pc = m_pc[k]; ipc = m_ipc[k]; fa = m_fa[k]; cnt = m_cnt[k];
      iv = m_iv[k]; fl = m_fl[k]; md = m_mode[k];
      legal = (redirect_target % 4 == 0) && (longint'(redirect_target) < ROM_LIMIT);
      if (reset) begin
        pc = 32'h0; ipc = 0; iv = 0; fl = 0; fa = 0; cnt = 0; md = 0;
      end else if (md == 0) begin
        if (redirect && !legal) begin
          md = 2; fl = 1; fa = redirect_target; iv = 0;
        end else if (redirect) begin
          ipc = pc;
          pc  = redirect_target;
          if (halt_req) begin md = 1; iv = 0; end
          else iv = (k == 1);
          if (iv) cnt = cnt + 1;
        end else if (halt_req) begin
          md = 1; iv = 0;
        end else if (!stall) begin
          ipc = pc; pc = pc + 4; iv = 1; cnt = cnt + 1;
        end
      end else begin
        iv = 0;
      end
      m_pc[k] <= pc; m_ipc[k] <= ipc; m_fa[k] <= fa; m_cnt[k] <= cnt;
      m_iv[k] <= iv; m_fl[k] <= fl; m_mode[k] <= md;
    end
    if (reset) m_init <= 1'b1;
  end

  always @(negedge clock) begin
    if (m_init) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rom_addr[%0d]", k),    rom_addr_w[k],    m_pc[k]);
        chk($sformatf("rom_stall[%0d]", k),   32'(rom_stall_w[k]),
            32'((m_mode[k] == 0) ? (stall & ~redirect) : 1'b1));
        chk($sformatf("inst_pc[%0d]", k),     inst_pc_w[k],     m_ipc[k]);
        chk($sformatf("inst_valid[%0d]", k),  32'(inst_valid_w[k]), 32'(m_iv[k]));
        chk($sformatf("fault[%0d]", k),       32'(fault_w[k]),  32'(m_fl[k]));
        chk($sformatf("fault_addr[%0d]", k),  fault_addr_w[k],  m_fa[k]);
        chk($sformatf("fetch_count[%0d]", k), fetch_count_w[k], m_cnt[k]);
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    reset = 1'b0;
    chk("lit reset rom_addr", rom_addr_w[1], 32'h0);
    chk("lit reset inst_valid", 32'(inst_valid_w[1]), 32'h0);
    chk("lit reset fetch_count", fetch_count_w[1], 32'h0);

    // Free run four cycles.
    tick(4);
    chk("lit run rom_addr", rom_addr_w[1], 32'h10);
    chk("lit run inst_pc", inst_pc_w[1], 32'hC);
    chk("lit run fetch_count", fetch_count_w[1], 32'd4);

    // Stall three cycles: everything holds.
    stall = 1'b1;
    tick(3);
    chk("lit stall rom_stall", 32'(rom_stall_w[1]), 32'h1);
    chk("lit stall rom_addr", rom_addr_w[1], 32'h10);
    chk("lit stall fetch_count", fetch_count_w[1], 32'd4);
    stall = 1'b0;
    tick(1);
    chk("lit resume inst_pc", inst_pc_w[1], 32'h10);

    // Redirect to 0x40 from pc 0x14: delay slot kept vs squashed.
    redirect = 1'b1; redirect_target = 32'h40;
    tick(1);
    redirect = 1'b0;
    chk("lit ds1 inst_pc", inst_pc_w[1], 32'h14);
    chk("lit ds1 inst_valid", 32'(inst_valid_w[1]), 32'h1);
    chk("lit ds1 fetch_count", fetch_count_w[1], 32'd6);
    chk("lit ds0 inst_valid", 32'(inst_valid_w[0]), 32'h0);
    chk("lit ds0 fetch_count", fetch_count_w[0], 32'd5);
    tick(1);
    chk("lit target inst_pc", inst_pc_w[0], 32'h40);

    // Redirect overrides stall.
    redirect = 1'b1; redirect_target = 32'h80; stall = 1'b1;
    #1;
    chk("lit redir+stall rom_stall", 32'(rom_stall_w[1]), 32'h0);
    tick(1);
    redirect = 1'b0; stall = 1'b0;
    chk("lit redir+stall rom_addr", rom_addr_w[1], 32'h80);

    // Last legal word, then sequential run past the ROM end: no fault.
    redirect = 1'b1; redirect_target = 32'h3FC;
    tick(1);
    redirect = 1'b0;
    tick(2);
    chk("lit seq past end rom_addr", rom_addr_w[1], 32'h404);
    chk("lit seq past end fault", 32'(fault_w[1]), 32'h0);

    // Redirect together with halt: redirect applied, then halted.
    redirect = 1'b1; redirect_target = 32'h20; halt_req = 1'b1;
    tick(1);
    for (int i = 0; i < 10; i++) begin
      redirect = (i % 2 == 0); redirect_target = 32'h100;
      stall = (i % 3 == 0); halt_req = (i % 2 == 1);
      tick(1);
    end
    chk("lit halted rom_addr", rom_addr_w[1], 32'h20);
    chk("lit halted rom_stall", 32'(rom_stall_w[1]), 32'h1);
    chk("lit halted inst_valid", 32'(inst_valid_w[1]), 32'h0);

    // Reset mid-halt with a pending redirect: reset wins.
    reset = 1'b1; redirect = 1'b1; redirect_target = 32'h200;
    tick(1);
    reset = 1'b0; redirect = 1'b0; stall = 1'b0; halt_req = 1'b0;
    chk("lit post-halt reset rom_addr", rom_addr_w[1], 32'h0);
    tick(3);
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    tick(2);
    chk("lit plain halt rom_addr", rom_addr_w[1], 32'hC);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;

    // Misaligned target faults.
    tick(2);
    redirect = 1'b1; redirect_target = 32'h42;
    tick(1);
    chk("lit fault flag", 32'(fault_w[1]), 32'h1);
    chk("lit fault_addr 0x42", fault_addr_w[1], 32'h42);
    redirect_target = 32'h40;
    tick(3);
    redirect = 1'b0;
    chk("lit faulted rom_addr", rom_addr_w[1], 32'h8);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("lit fault cleared", 32'(fault_w[1]), 32'h0);

    // Out-of-range targets fault.
    tick(1);
    redirect = 1'b1; redirect_target = 32'h400;
    tick(1);
    redirect = 1'b0;
    chk("lit fault_addr 0x400", fault_addr_w[0], 32'h400);
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    redirect = 1'b1; redirect_target = 32'h8000_0000;
    tick(1);
    redirect = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2);

    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
